// File: rtl/pc_update_unit.sv
// Program counter and next-PC sequencer; redirects resolved during a memory stall are held and applied on release.
// Latency: PC/FLUSH registered (redirect visible one cycle after decode); PC_PLUS4 combinational from PC.
// Backpressure: BUSYWAIT high freezes PC. Optional counters are enabled by PC_PERF_CNT_EN.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUSYWAIT,
  input  logic        JUMP,
  input  logic        BRANCH,
  input  logic        BNE,
  input  logic        ZERO,
  input  logic [31:0] TARGET,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FLUSH,
  output logic [31:0] INSTR_COUNT,
  output logic [15:0] TAKEN_COUNT
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_load, pc_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic        flush, flush_nxt;
  logic        taken;

  assign taken    = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
  assign PC_PLUS4 = pc + 32'd4;
  assign PC       = pc;
  assign FLUSH    = flush;

  // Every PC load, including redirects, is kept word aligned.
  assign pc_nxt = pc_load & 32'hFFFF_FFFC;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_RESET;
      pc       <= RESET_PC & 32'hFFFF_FFFC;
      pend_vld <= 1'b0;
      pend_tgt <= 32'h0;
      flush    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_vld <= pend_vld_nxt;
      pend_tgt <= pend_tgt_nxt;
      flush    <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_load      = pc;
    pend_vld_nxt = pend_vld;
    pend_tgt_nxt = pend_tgt;
    flush_nxt    = 1'b0;
    case (state)
      S_RESET: begin
        // First edge out of reset holds RESET_PC for one fetch.
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!BUSYWAIT) begin
          pc_load   = taken ? TARGET : PC_PLUS4;
          flush_nxt = taken;
        end else begin
          if (taken) begin
            pend_vld_nxt = 1'b1;
            pend_tgt_nxt = TARGET;
          end
          state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (BUSYWAIT) begin
          if (taken) begin
            pend_vld_nxt = 1'b1;
            pend_tgt_nxt = TARGET;
          end
        end else begin
          // A live redirect on the release edge overrides the buffered one.
          if (taken) begin
            pc_load = TARGET;
          end else if (pend_vld) begin
            pc_load = pend_tgt;
          end else begin
            pc_load = PC_PLUS4;
          end
          flush_nxt    = taken | pend_vld;
          pend_vld_nxt = 1'b0;
          state_nxt    = S_RUN;
        end
      end
      default: begin
        state_nxt = S_RESET;
      end
    endcase
  end

`ifdef PC_PERF_CNT_EN
  logic [31:0] instr_cnt;
  logic [15:0] taken_cnt;
  logic        advance;

  assign advance = (state != S_RESET) && !BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      instr_cnt <= 32'h0;
      taken_cnt <= 16'h0;
    end else begin
      if (advance) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
      if (flush_nxt && (taken_cnt != 16'hFFFF)) begin
        taken_cnt <= taken_cnt + 16'd1;
      end
    end
  end

  assign INSTR_COUNT = instr_cnt;
  assign TAKEN_COUNT = taken_cnt;
`else
  assign INSTR_COUNT = 32'h0;
  assign TAKEN_COUNT = 16'h0;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed and random stimulus for pc_update_unit against a cycle-level reference model of the PC rules.
module tb_pc_update_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        BUSYWAIT = 1'b0;
  logic        JUMP = 1'b0;
  logic        BRANCH = 1'b0;
  logic        BNE = 1'b0;
  logic        ZERO = 1'b0;
  logic [31:0] TARGET = 32'h0;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        FLUSH;
  logic [31:0] INSTR_COUNT;
  logic [15:0] TAKEN_COUNT;

  int checks = 0;
  int failures = 0;

  // Reference model: what the PC should be, which redirect is waiting, counters.
  logic [31:0] m_pc = 32'h0;
  logic        m_hold_first = 1'b1;
  logic        m_pend_vld = 1'b0;
  logic [31:0] m_pend = 32'h0;
  logic        m_flush = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [15:0] m_taken = 16'h0;

  pc_update_unit #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BUSYWAIT(BUSYWAIT),
    .JUMP(JUMP),
    .BRANCH(BRANCH),
    .BNE(BNE),
    .ZERO(ZERO),
    .TARGET(TARGET),
    .PC(PC),
    .PC_PLUS4(PC_PLUS4),
    .FLUSH(FLUSH),
    .INSTR_COUNT(INSTR_COUNT),
    .TAKEN_COUNT(TAKEN_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, bw, j, br, bn, z, input logic [31:0] tgt);
    logic tk;
    tk = j || (br && z) || (bn && !z);
    m_flush = 1'b0;
    if (rst) begin
      m_pc = RESET_PC;
      m_hold_first = 1'b1;
      m_pend_vld = 1'b0;
      m_instr = 0;
      m_taken = 0;
    end else if (m_hold_first) begin
      m_hold_first = 1'b0;
    end else if (bw) begin
      if (tk) begin
        m_pend_vld = 1'b1;
        m_pend = tgt;
      end
    end else begin
      if (tk) begin
        m_pc = {tgt[31:2], 2'b00};
        m_flush = 1'b1;
      end else if (m_pend_vld) begin
        m_pc = {m_pend[31:2], 2'b00};
        m_flush = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_pend_vld = 1'b0;
      m_instr = m_instr + 1;
      if (m_flush && m_taken != 16'hFFFF) m_taken = m_taken + 1;
    end
  endtask

  // One clock edge with the given inputs, then compare every output with the model.
  task automatic step(input logic rst, bw, j, br, bn, z, input logic [31:0] tgt);
    RESET = rst; BUSYWAIT = bw; JUMP = j; BRANCH = br; BNE = bn; ZERO = z; TARGET = tgt;
    @(posedge CLK);
    model_edge(rst, bw, j, br, bn, z, tgt);
    #1;
    chk("pc", PC, m_pc);
    chk("pc_plus4", PC_PLUS4, m_pc + 32'd4);
    chk("flush", {31'b0, FLUSH}, {31'b0, m_flush});
`ifdef PC_PERF_CNT_EN
    chk("instr_count", INSTR_COUNT, m_instr);
    chk("taken_count", {16'b0, TAKEN_COUNT}, {16'b0, m_taken});
`else
    chk("instr_count", INSTR_COUNT, 32'h0);
    chk("taken_count", {16'b0, TAKEN_COUNT}, 32'h0);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic jump_to(input logic [31:0] t);
    step(0, 0, 1, 0, 0, 0, t);
  endtask

  initial begin
    #3;
    // Reset and first fetch: 0, 0, 4, 8.
    step(1, 0, 0, 0, 0, 0, 32'h0);
    chk("reset_pc", PC, 32'h0);
    chk("reset_flush", {31'b0, FLUSH}, 32'h0);
    chk("reset_instr", INSTR_COUNT, 32'h0);
    idle(); chk("hold_first", PC, 32'h0);
    idle(); chk("seq_4", PC, 32'h4);
    idle(); chk("seq_8", PC, 32'h8);
    idle(); idle(); chk("seq_10", PC, 32'h10);

    // Jump 0x10 -> 0x40, then sequential.
    jump_to(32'h40); chk("jump_pc", PC, 32'h40); chk("jump_flush", {31'b0, FLUSH}, 32'h1);
    idle(); chk("after_jump", PC, 32'h44); chk("flush_one_cycle", {31'b0, FLUSH}, 32'h0);

    // BEQ not taken from 0x10.
    jump_to(32'h10);
    step(0, 0, 0, 1, 0, 0, 32'h80); chk("beq_not_taken", PC, 32'h14);

    // BNE taken during a three-cycle stall from 0x20.
    jump_to(32'h20);
    step(0, 1, 0, 0, 1, 0, 32'h80); chk("stall_hold0", PC, 32'h20);
    step(0, 1, 0, 0, 0, 0, 32'h0);  chk("stall_hold1", PC, 32'h20);
    step(0, 1, 0, 0, 0, 0, 32'h0);  chk("stall_hold2", PC, 32'h20);
    chk("stall_no_flush", {31'b0, FLUSH}, 32'h0);
    idle(); chk("release_pend", PC, 32'h80); chk("release_flush", {31'b0, FLUSH}, 32'h1);
    idle(); chk("after_release", PC, 32'h84); chk("release_flush_off", {31'b0, FLUSH}, 32'h0);

    // Live jump on release overrides the pending 0x80.
    jump_to(32'h100);
    step(0, 1, 1, 0, 0, 0, 32'h80);
    step(0, 1, 0, 0, 0, 0, 32'h0); chk("pend_not_loaded", PC, 32'h100);
    step(0, 0, 1, 0, 0, 0, 32'hC0); chk("live_wins", PC, 32'hC0);
    idle(); chk("live_wins_next", PC, 32'hC4);

    // Misaligned target is forced to a word boundary.
    jump_to(32'h33); chk("align", PC, 32'h30);

    // Wrap at the top of the address space.
    jump_to(32'hFFFF_FFFC); chk("plus4_wrap", PC_PLUS4, 32'h0);
    idle(); chk("pc_wrap", PC, 32'h0);

    // Reset during a stall with a pending redirect.
    jump_to(32'h300);
    step(0, 1, 1, 0, 0, 0, 32'h200);
    step(1, 1, 0, 0, 0, 0, 32'h0); chk("rst_stall_pc", PC, RESET_PC);
    chk("rst_stall_instr", INSTR_COUNT, 32'h0);
    idle(); chk("rst_drop_hold", PC, RESET_PC); chk("rst_drop_flush", {31'b0, FLUSH}, 32'h0);
    idle(); chk("rst_drop_adv", PC, RESET_PC + 32'h4);

    // Ten advances with two redirects.
    step(1, 0, 0, 0, 0, 0, 32'h0);
    idle();
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) jump_to(32'h1000 + 32'(i) * 32'h40);
      else idle();
    end
`ifdef PC_PERF_CNT_EN
    chk("perf_instr", INSTR_COUNT, 32'd10);
    chk("perf_taken", {16'b0, TAKEN_COUNT}, 32'd2);
`else
    chk("perf_instr_off", INSTR_COUNT, 32'd0);
    chk("perf_taken_off", {16'b0, TAKEN_COUNT}, 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
           ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter register and next-PC sequencer for the single-cycle CPU. Holds the current PC, produces PC+4 for the jump/branch target adder, and consumes that adder's 32-bit TARGET to redirect fetch on taken jumps and branches. Stalls on instruction/data memory BUSYWAIT and buffers a redirect resolved during a stall so that it is applied when the stall releases.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BUSYWAIT  input  1  memory stall; high = hold PC.
- JUMP  input  1  unconditional jump decoded this cycle.
- BRANCH  input  1  branch-if-equal decoded this cycle.
- BNE  input  1  branch-if-not-equal decoded this cycle.
- ZERO  input  1  ALU zero flag.
- TARGET  input  32  jump/branch target from the jump/branch target adder, which is computed from PC_PLUS4 + sign-extended offset×4.
- PC  output  32  current instruction address (registered).
- PC_PLUS4  output  32  PC + 4, combinational; drives the target adder's PC input.
- FLUSH  output  1  registered; high for one cycle after a redirect is loaded.
- INSTR_COUNT  output  32  PC-advance counter (see Configuration).
- TAKEN_COUNT  output  16  redirect counter (see Configuration).

## Operation

- Taken = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO), evaluated on every rising edge.
- PC_PLUS4 = PC + 32'd4, modulo 2^32 (wraps FFFF_FFFC → 0000_0000).
- Any value loaded into PC has bits [1:0] forced to 00.
- Pending buffer: PEND_VALID (1 bit) and PEND_TARGET (32 bits).
- FSM states:
  - S_RESET: entered on any edge with RESET=1, from any state. PC=RESET_PC, PEND_VALID=0, FLUSH=0, and counters are cleared. On the first edge with RESET=0, go to S_RUN with PC unchanged.
  - S_RUN, BUSYWAIT=0: PC ← Taken ? TARGET : PC_PLUS4, then stay in S_RUN.
  - S_RUN, BUSYWAIT=1: PC holds; if Taken, then PEND_VALID←1 and PEND_TARGET←TARGET; go to S_STALL.
  - S_STALL, BUSYWAIT=1: PC holds; if Taken, PEND_TARGET←TARGET and PEND_VALID←1 (latest wins).
  - S_STALL, BUSYWAIT=0: PC ← Taken ? TARGET : (PEND_VALID ? PEND_TARGET : PC_PLUS4); PEND_VALID←0; go to S_RUN.
- Simultaneous live Taken and PEND_VALID at release: the live TARGET wins and the pending entry is discarded.
- FLUSH ← 1 on any edge that loads PC from TARGET or PEND_TARGET; otherwise 0.
- RESET mid-stall with a pending redirect: the pending redirect is dropped, and the PC goes to RESET_PC.

## Timing

- PC, FLUSH, the FSM state and the counters are all registered and update on the CLK rising edge only.
- Reset values: PC=RESET_PC, FLUSH=0, INSTR_COUNT=0, TAKEN_COUNT=0, PEND_VALID=0, state=S_RESET.
- PC_PLUS4 is purely combinational from PC; zero-cycle latency.
- TARGET, the control inputs and ZERO must be stable before the rising edge. The adder's propagation delay falls within the same cycle, so a redirect has one-cycle latency: decode in cycle n, PC=TARGET in cycle n+1.
- Stall release: the PC advances on the first edge where BUSYWAIT=0. There are no bubble cycles beyond the stall itself.
- First fetch after reset: PC=RESET_PC is held for exactly one cycle after RESET falls.

## Configuration

- PC_PERF_CNT_EN defined:
  - INSTR_COUNT increments on every edge where the PC is loaded in S_RUN or on stall release; it wraps modulo 2^32.
  - TAKEN_COUNT increments on every edge where FLUSH is set; it saturates at 16'hFFFF.
  - Both counters clear on RESET.
- PC_PERF_CNT_EN undefined: there is no counter logic, and INSTR_COUNT and TAKEN_COUNT are tied to 0. The ports remain present.

## Test plan

- Reset, then release RESET with BUSYWAIT=0 and no control asserted for 3 edges → PC sequence 0, 0, 4, 8; FLUSH=0 throughout.
- With PC=0x10, assert JUMP with TARGET=0x40 → next PC=0x40, FLUSH=1 for one cycle, then PC=0x44. Repeat with BRANCH=1, ZERO=0 → no redirect, PC=0x14.
- With PC=0x20, assert BNE=1, ZERO=0, TARGET=0x80, and BUSYWAIT=1 for 3 cycles, deasserting the controls after the first cycle → PC holds 0x20 during the stall, loads 0x80 on release, FLUSH pulses once.
- In a stall with a pending target 0x80, assert JUMP with TARGET=0xC0 on the release edge → PC=0xC0, and 0x80 is never loaded.
- With PC=0xFFFF_FFFC and no branch → PC_PLUS4=0 and the next PC=0. Assert RESET during a stall with a pending redirect → PC=RESET_PC, PEND dropped, counters=0.
- With PC_PERF_CNT_EN defined, run 10 advances including 2 redirects → INSTR_COUNT=10, TAKEN_COUNT=2. With the macro undefined, the same run gives both counters 0.
